// File: rtl/ram_pkg.sv
// Shared definitions for the RAM read-side burst master and its helpers.
package ram_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int RAM_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rd_state_t;
endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM, 1K x 8, read data registered one cycle after address.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);
    logic [DATA_W-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem_q[address] <= data_in;
        end
        data_out <= mem_q[address];
    end
endmodule

// File: rtl/ram_rd_fifo2.sv
// Two-entry FIFO holding returned read bytes plus their end-of-burst tag.
module ram_rd_fifo2
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              head_last_o,
    output logic [1:0]        count_o
);
    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        last_q;
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    // Push is never gated: the issue rule upstream keeps occupancy at or below two.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data_o = data_q[rd_ptr_q];
    assign head_last_o = last_q[rd_ptr_q];
    assign count_o     = count_q;
endmodule

// File: rtl/ram_burst_reader.sv
// Read-side burst master: issues back-to-back RAM reads and streams the bytes
// out on valid/ready, throttled so at most two bytes are ever buffered or in flight.
module ram_burst_reader
    import ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = 11
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    rd_state_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic [2:0]        level;

    assign pop        = out_valid & out_ready;
    // Buffered plus in-flight bytes, less the one leaving this cycle, must stay below two.
    assign level      = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign issue      = (state_q == READ) && (level < (3'd2 + {2'b00, pop}));
    assign last_issue = issue && (remaining_q == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            done_q          <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state_q     <= READ;
                            busy_q      <= 1'b1;
                            addr_q      <= start_addr;
                            remaining_q <= length;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (last_issue) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    ram_rd_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (inflight_q),
        .push_data_i(data_out),
        .push_last_i(inflight_last_q),
        .pop_i      (pop),
        .head_data_o(out_data),
        .head_last_o(out_last),
        .count_o    (fifo_count)
    );

    assign out_valid    = (fifo_count != 2'd0);
    assign busy         = busy_q;
    assign done         = done_q;
    assign address      = addr_q;
    assign write_enable = 1'b0;
    assign data_in      = '0;
endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: real RAM beside the DUT, shadow memory model and
// an expected-byte queue compared against every stream handshake.
module tb_ram_burst_reader;
    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic        write_enable;
    logic [9:0]  address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    logic        tb_load;
    logic        tb_we;
    logic [9:0]  tb_addr;
    logic [7:0]  tb_wdata;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wdata;

    logic [7:0]  model_mem [1024];
    logic [8:0]  exp_q [$];
    logic [8:0]  mon_exp;

    int n_err = 0;
    int n_chk = 0;
    int bytes_seen = 0;
    int done_cnt = 0;
    int fifo_max = 0;
    logic we_seen = 1'b0;
    logic held_valid = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic held_last = 1'b0;

    assign ram_we    = tb_load ? tb_we    : write_enable;
    assign ram_addr  = tb_load ? tb_addr  : address;
    assign ram_wdata = tb_load ? tb_wdata : data_in;

    ram u_ram (
        .clk         (clk),
        .write_enable(ram_we),
        .address     (ram_addr),
        .data_in     (ram_wdata),
        .data_out    (data_out)
    );

    ram_burst_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .write_enable(write_enable),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input int a, input logic [7:0] d);
        tb_load  = 1'b1;
        tb_we    = 1'b1;
        tb_addr  = 10'(a);
        tb_wdata = d;
        model_mem[a] = d;
        tick();
        tb_we   = 1'b0;
        tb_load = 1'b0;
    endtask

    // Called in an IDLE cycle; returns in cycle 1 of the burst.
    task automatic start_burst(input int a, input int n);
        start      = 1'b1;
        start_addr = 10'(a);
        length     = 11'(n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), model_mem[(a + i) % 1024]});
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int c;
        c = 0;
        while (!done && c < max_cyc) begin
            tick();
            c++;
        end
        check_eq(tag, done, 1);
    endtask

    // Stream monitor: scoreboard pops, stall stability, occupancy and done count.
    always @(negedge clk) begin
        if (reset) begin
            held_valid = 1'b0;
        end else begin
            if (write_enable) we_seen = 1'b1;
            if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
            if (done) done_cnt++;
            if (held_valid) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data", out_data, held_data);
                check_eq("stall_last", out_last, held_last);
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
            if (out_valid && out_ready) begin
                bytes_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("extra_byte", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_eq("byte_data", out_data, mon_exp[7:0]);
                    check_eq("byte_last", out_last, mon_exp[8]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int d0;
        int c;
        reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
        tb_load = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int a = 0; a < 1024; a++) ram_write(a, 8'(a * 7 + 3));
        for (int i = 0; i < 4; i++) ram_write(55 + i, 8'(8'h56 + i));
        for (int i = 0; i < 4; i++) ram_write((1022 + i) % 1024, 8'(8'hA0 + i));
        ram_write(66, 8'h36);

        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_addr", address, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_we", write_enable, 0);
        check_eq("rst_din", data_in, 0);
        reset = 1'b0;
        tick();

        // Basic burst, latency and done timing.
        b0 = bytes_seen;
        start_burst(55, 4);
        check_eq("b1_c1_busy", busy, 1);
        check_eq("b1_c1_valid", out_valid, 0);
        check_eq("b1_c1_addr", address, 55);
        tick();
        check_eq("b1_c2_valid", out_valid, 0);
        check_eq("b1_c2_addr", address, 56);
        tick();
        check_eq("b1_c3_valid", out_valid, 1);
        check_eq("b1_c3_data", out_data, 8'h56);
        tick(); tick(); tick();
        check_eq("b1_c6_data", out_data, 8'h59);
        check_eq("b1_c6_last", out_last, 1);
        tick();
        check_eq("b1_c7_done", done, 1);
        check_eq("b1_c7_busy", busy, 0);
        check_eq("b1_c7_valid", out_valid, 0);
        tick();
        check_eq("b1_c8_done", done, 0);
        check_eq("b1_bytes", bytes_seen - b0, 4);

        // Backpressure: ready low cycles 3-8, then toggling.
        b0 = bytes_seen;
        out_ready = 1'b0;
        start_burst(55, 4);
        for (c = 1; c <= 8; c++) tick();
        c = 9;
        while (!done && c < 60) begin
            out_ready = c[0];
            tick();
            c++;
        end
        check_eq("bp_done", done, 1);
        out_ready = 1'b1;
        check_eq("bp_bytes", bytes_seen - b0, 4);
        tick();

        // Address wrap-around.
        start_burst(1022, 4);
        check_eq("wr_addr0", address, 1022);
        tick();
        check_eq("wr_addr1", address, 1023);
        tick();
        check_eq("wr_addr2", address, 0);
        tick();
        check_eq("wr_addr3", address, 1);
        wait_done("wr_done", 20);
        tick();

        // Zero length.
        b0 = bytes_seen;
        start_burst(10, 0);
        check_eq("z_done", done, 1);
        check_eq("z_busy", busy, 0);
        check_eq("z_valid", out_valid, 0);
        tick();
        check_eq("z_done_clr", done, 0);
        check_eq("z_valid2", out_valid, 0);

        // Start while busy is ignored.
        d0 = done_cnt;
        start_burst(55, 4);
        tick();
        start = 1'b1; start_addr = 10'd66; length = 11'd3;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check_eq("ig_done_cnt", done_cnt - d0, 1);
        check_eq("ig_bytes", bytes_seen - b0, 4);
        check_eq("ig_busy", busy, 0);

        // Reset mid-burst.
        d0 = done_cnt;
        start_burst(100, 10);
        tick(); tick();
        reset = 1'b1;
        tick();
        check_eq("mr_busy", busy, 0);
        check_eq("mr_valid", out_valid, 0);
        check_eq("mr_done", done, 0);
        check_eq("mr_data", out_data, 0);
        check_eq("mr_addr", address, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (4) tick();
        check_eq("mr_no_done", done_cnt - d0, 0);
        check_eq("mr_idle_valid", out_valid, 0);
        start_burst(66, 2);
        tick(); tick();
        check_eq("mr_first_valid", out_valid, 1);
        check_eq("mr_first_data", out_data, 8'h36);
        wait_done("mr_done2", 20);
        tick();

        // Full depth.
        b0 = bytes_seen;
        start_burst(0, 1024);
        c = 1;
        while (!done && c < 1100) begin
            tick();
            c++;
        end
        check_eq("fd_done_cycle", c, 1027);
        check_eq("fd_bytes", bytes_seen - b0, 1024);
        tick();

        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("fifo_le2", (fifo_max <= 2), 1);
        check_eq("we_never", we_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side master for the single-port 1K×8 synchronous `ram` block. It takes a start address and length, issues back-to-back reads on the RAM port, and streams the returned bytes out on a valid/ready interface. It tolerates arbitrary downstream backpressure without dropping or duplicating bytes. It sits between the RAM and any byte consumer (UART TX, checksum, display), complementing the existing write-side stimulus that loads the RAM.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM address width; address space is 2^ADDR_W bytes.
- `DATA_W`, default 8: RAM data width.
- `LEN_W`, default 11: burst length width; lengths 0..1024 are legal.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: burst request; sampled only in IDLE.
- `start_addr`  in  ADDR_W: first byte address.
- `length`  in  LEN_W: byte count.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle pulse at burst end.
- `write_enable`  out  1: to RAM; constant 0.
- `address`  out  ADDR_W: to RAM; registered.
- `data_in`  out  DATA_W: to RAM; constant 0.
- `data_out`  in  DATA_W: from RAM; valid one cycle after `address` is presented.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: stream ready.
- `out_data`  out  DATA_W: stream byte.
- `out_last`  out  1: marks the final byte of the burst.

## Operation
- **Reset values:** `busy`=0, `done`=0, `address`=0, `out_valid`=0, `out_data`=0, `out_last`=0. FSM goes to IDLE, FIFO is empty, in-flight flag is cleared.
- **FSM states:** IDLE, READ, DRAIN, DONE.
  - IDLE→READ on `start` with `length`≠0. Latch `address`←`start_addr`, `remaining`←`length`.
  - IDLE→DONE on `start` with `length`=0.
  - READ→DRAIN when the last read is issued (`remaining` reaches 0).
  - DRAIN→DONE on the handshake of the byte with `out_last`.
  - DONE→IDLE unconditionally.
- **Issue rule (READ only):** issue when `fifo_count + inflight − pop < 2`, where `pop` = `out_valid & out_ready`.
  - On issue: `address` increments mod 2^ADDR_W (1023→0 wraps), `remaining` decrements, and `inflight` is set for the next cycle.
- **Capture:** when `inflight` is 1, push `data_out` into the 2-entry FIFO, tagged last if it was the final issued read.
  - FIFO overflow cannot occur by construction. The bench asserts this.
- **Output:** `out_valid` = FIFO non-empty. While `out_valid & !out_ready`, `out_data` and `out_last` hold stable.
- `busy` = state ∈ {READ, DRAIN}. `done` = state is DONE.
- `start` outside IDLE is ignored; burst parameters are not re-latched.
- `reset` mid-burst aborts it immediately: no `done` pulse, and FIFO contents are discarded.
- `write_enable` is never asserted.

## Timing
- `start` sampled at edge E0:
  - cycle 1: first read issued; `busy`=1.
  - cycle 2: `data_out` valid and captured.
  - cycle 3: first `out_valid`.
  - Start-to-first-valid latency is 3 cycles.
- With `out_ready` held high, throughput is 1 byte/cycle.
  - For length N, the last byte is valid in cycle N+2.
  - `done` pulses in cycle N+3; `busy` drops the same cycle.
- `length`=0: `done`=1 in cycle 1, `busy` stays 0, no `out_valid`.
- Next `start` is accepted the cycle after DONE (IDLE).
- `out_valid` never deasserts without a handshake.

## Structure
- Package `ram_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults;
  - `RAM_DEPTH` = 1024;
  - the state enum `rd_state_t` {IDLE, READ, DRAIN, DONE}.
- Sub-module `ram_rd_fifo2` is a 2-entry FIFO (data + last bit) with push/pop/count.
- The top level contains the FSM, address/remaining counters, and the inflight flag. It instantiates `ram_rd_fifo2`.
- The bench instantiates `ram` alongside this block.

## Test plan
1. **Basic burst:** preload addr 55..58 = 0x56,0x57,0x58,0x59; `start_addr`=55, `length`=4, `out_ready`=1.
   → bytes 0x56..0x59 in cycles 3–6; `out_last` on 0x59; `done` in cycle 7.
2. **Backpressure:** same burst with `out_ready` low for cycles 3–8, then toggled every cycle.
   → exactly 4 bytes in order; `out_data` stable while stalled; FIFO never exceeds 2.
3. **Wrap-around:** preload 1022,1023,0,1 = 0xA0..0xA3; `start_addr`=1022, `length`=4.
   → 0xA0,0xA1,0xA2,0xA3; `address` sequence 1022,1023,0,1.
4. **Zero length and ignored start:** `length`=0 → `done`=1 in cycle 1, no `out_valid`. Separately, pulse `start` with addr 66 during a busy burst.
   → the burst continues from its original address; no second `done`.
5. **Reset mid-burst:** `reset` at cycle 4 of a 10-byte burst.
   → next cycle `busy`=0, `out_valid`=0, `done`=0. A following burst from addr 66 (0x36) returns 0x36 first.
6. **Full depth:** `length`=1024 from addr 0 with `out_ready`=1 → 1024 bytes matching RAM contents; `out_last` only on the 1024th.
